decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
Parametrised decode-to-execute stage for the pipelined ARM core. It contains the architectural register file with a configurable number of read ports, write-first bypass from writeback and R15 mapped to PC+8. A valid/ready-handshaked D/E pipeline register carries operands, immediate, control word, destination, condition and flags into execute, with flush support. It replaces the fixed three-read decode register file and the unstallable D/E pipe.

Parameters:
DATA_W, 32, register/operand width
ADDR_W, 4, register address width; file holds 2**ADDR_W entries, top entry is PC
NUM_READ, 3, number of read ports (1..4)
CTRL_W, 12, width of opaque control word forwarded to execute

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_ra  in  NUM_READ*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
in_wa  in  ADDR_W  destination register
in_imm  in  DATA_W  extended immediate
in_ctrl  in  CTRL_W  control word (ALU op, ALUSrc, RegWrite, Branch, ...)
in_mem_to_reg  in  1  instruction is a load
in_cond  in  4  condition field
in_flags  in  4  current NZCV
pc_plus8  in  DATA_W  value returned for reads of R15
wb_we  in  1  writeback enable
wb_wa  in  ADDR_W  writeback address
wb_wd  in  DATA_W  writeback data
flush  in  1  kill instruction held in D/E register
out_valid  out  1  execute payload valid
out_ready  in  1  execute consumes payload
out_rd  out  NUM_READ*DATA_W  registered operands
out_imm, out_ctrl, out_mem_to_reg, out_wa, out_cond, out_flags  out  DATA_W, CTRL_W, 1, ADDR_W, 4, 4  registered copies

Behaviour:
- Reset: all register-file entries 0; out_valid=0; every out_* payload 0. Reset overrides flush, load and writes in the same cycle.
- Register file: write on rising clk when wb_we and wb_wa != 2**ADDR_W-1. Writes to R15 are ignored; PC is owned by fetch.
- Read port k: if in_ra[k] is R15, return pc_plus8. Else if wb_we and wb_wa==in_ra[k], return wb_wd (write-first bypass). Else return the stored entry. Reads are combinational.
- Handshake: in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
- Pipeline register update, priority order: (1) reset; (2) flush -> out_valid=0, payload held, accept ignored (in_ready still reported, but the instruction is dropped); (3) accept -> capture all payload, out_valid=1; (4) out_valid && out_ready && !in_valid -> out_valid=0; (5) otherwise hold.
- Latency: 1 cycle from accept to out_valid. Back-to-back throughput of 1/cycle when out_ready=1.
- Stall: out_valid=1 and out_ready=0 -> payload stable, in_ready=0.
- Operands are captured at accept; a later writeback does not update the held out_rd (execute-stage forwarding handles that).

Optional Feature:
DECODE_LOAD_USE_STALL_EN
- Defined: the stage detects load-use hazards. A hazard exists when out_valid && out_mem_to_reg && out_wa != R15 and any in_ra[k]==out_wa. During a hazard, in_ready is forced to 0 regardless of out_ready. When execute consumes the load (out_ready=1), the stage inserts a bubble (out_valid=0) for one cycle. The instruction is then accepted the following cycle, so the stall is exactly 1 cycle.
- Not defined: no hazard logic; in_ready follows the base equation only.

Test Plan:
- Reset then read: reset 1 cycle, in_ra={1,2,15}, pc_plus8=0x108, accept -> next cycle out_valid=1, out_rd={0,0,0x108}.
- Bypass: wb_we=1, wb_wa=3, wb_wd=0xDEADBEEF with same-cycle accept of in_ra[0]=3 -> out_rd[0]=0xDEADBEEF. A later read of r3 returns 0xDEADBEEF. A write to R15 with 0x55 -> R15 read still returns pc_plus8.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, payload unchanged (in_imm=0x7 held). On out_ready=1, the next instruction (in_imm=0x8) is captured the same cycle.
- Flush: out_valid=1, flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, new instruction dropped.
- Throughput: 4 instructions with in_imm 1..4, out_ready=1 -> out_imm 1,2,3,4 on consecutive cycles, no gaps.
- With DECODE_LOAD_USE_STALL_EN: load to r5 in E, next instruction reads r5 -> in_ready=0 one cycle, one bubble, then the dependent instruction accepted. Without the macro, the same stimulus gives no bubble.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//
// Decode-to-execute stage of the pipelined ARM core.
//   * Architectural register file (2**ADDR_W entries) with NUM_READ
//     combinational read ports.
//   * The top entry is the PC. Reads of it return pc_plus8 and writes to it
//     are dropped, because fetch owns the PC.
//   * Write-first bypass: a read of the register being written back in the
//     same cycle returns the writeback data.
//   * valid/ready D/E pipeline register carrying operands, immediate,
//     control word, destination, condition and flags into execute.
//     Supports flush and backpressure.
//
// Optional feature (compile-time macro DECODE_LOAD_USE_STALL_EN):
//   Load-use hazard detection. The stage holds off a dependent instruction
//   while a load sits in execute. When execute consumes the load, the stage
//   inserts one bubble, so the stall is exactly one cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   decode-side handshake
//   in_ra                 NUM_READ packed read addresses (port k at k*ADDR_W)
//   in_wa                 destination register
//   in_imm                extended immediate
//   in_ctrl               opaque control word for execute
//   in_mem_to_reg         instruction is a load
//   in_cond, in_flags     condition field, current NZCV
//   pc_plus8              value returned for reads of the PC register
//   wb_we, wb_wa, wb_wd   writeback port
//   flush                 kill the instruction held in the D/E register
//   out_valid / out_ready execute-side handshake
//   out_rd                NUM_READ packed operands captured at accept
//   out_imm, out_ctrl, out_mem_to_reg, out_wa, out_cond, out_flags
//                         registered payload copies
// ---------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_READ = 3,
    parameter int CTRL_W   = 12
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_READ*ADDR_W-1:0]   in_ra,
    input  logic [ADDR_W-1:0]            in_wa,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         in_mem_to_reg,
    input  logic [3:0]                   in_cond,
    input  logic [3:0]                   in_flags,
    input  logic [DATA_W-1:0]            pc_plus8,

    input  logic                         wb_we,
    input  logic [ADDR_W-1:0]            wb_wa,
    input  logic [DATA_W-1:0]            wb_wd,

    input  logic                         flush,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_READ*DATA_W-1:0]   out_rd,
    output logic [DATA_W-1:0]            out_imm,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic                         out_mem_to_reg,
    output logic [ADDR_W-1:0]            out_wa,
    output logic [3:0]                   out_cond,
    output logic [3:0]                   out_flags
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX   = '1;

    // Register file storage. The PC entry is never written and never
    // selected on a read; it exists only to keep indexing full-range.
    logic [DATA_W-1:0] regFile [NUM_REGS];

    // Decode-side (stage 0) combinational signals
    logic [NUM_READ*DATA_W-1:0] rdData_p0;
    logic                       inReady_p0;
    logic                       accept_p0;

    // D/E register (stage 1) state
    logic                       vld_p1;
    logic [NUM_READ*DATA_W-1:0] rd_p1;
    logic [DATA_W-1:0]          imm_p1;
    logic [CTRL_W-1:0]          ctrl_p1;
    logic                       memToReg_p1;
    logic [ADDR_W-1:0]          wa_p1;
    logic [3:0]                 cond_p1;
    logic [3:0]                 flags_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (wb_we && (wb_wa != PC_IDX)) begin
            regFile[wb_wa] <= wb_wd;
        end
    end

    // ---- stage 0: register read ----
    // PC mapping takes precedence over the bypass, so a stray writeback
    // aimed at the PC can never leak into an operand.
    for (genvar k = 0; k < NUM_READ; k++) begin : gRead
        logic [ADDR_W-1:0] ra;
        assign ra = in_ra[k*ADDR_W +: ADDR_W];
        assign rdData_p0[k*DATA_W +: DATA_W] =
            (ra == PC_IDX)              ? pc_plus8 :
            (wb_we && (wb_wa == ra))    ? wb_wd    :
                                          regFile[ra];
    end

`ifdef DECODE_LOAD_USE_STALL_EN
    // A load in execute whose destination matches any source blocks
    // acceptance. Once execute takes the load, the D/E register drains
    // (out_valid drops) because nothing was accepted. That drain is the
    // single bubble, and the hazard clears on the following cycle.
    logic [NUM_READ-1:0] raHit;
    logic                loadUse_p0;

    for (genvar k = 0; k < NUM_READ; k++) begin : gHaz
        assign raHit[k] = (in_ra[k*ADDR_W +: ADDR_W] == wa_p1);
    end

    assign loadUse_p0 = vld_p1 && memToReg_p1 && (wa_p1 != PC_IDX) && (|raHit);
    assign inReady_p0 = !loadUse_p0 && (!vld_p1 || out_ready);
`else
    assign inReady_p0 = !vld_p1 || out_ready;
`endif

    assign accept_p0 = in_valid && inReady_p0;
    assign in_ready  = inReady_p0;

    // ---- stage 1: D/E pipeline register ----
    // Flush outranks accept: in_ready may still be high, but the incoming
    // instruction is dropped. Operands are frozen at accept; later
    // writebacks are left to execute-stage forwarding.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            rd_p1       <= '0;
            imm_p1      <= '0;
            ctrl_p1     <= '0;
            memToReg_p1 <= 1'b0;
            wa_p1       <= '0;
            cond_p1     <= '0;
            flags_p1    <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
        end else if (accept_p0) begin
            vld_p1      <= 1'b1;
            rd_p1       <= rdData_p0;
            imm_p1      <= in_imm;
            ctrl_p1     <= in_ctrl;
            memToReg_p1 <= in_mem_to_reg;
            wa_p1       <= in_wa;
            cond_p1     <= in_cond;
            flags_p1    <= in_flags;
        end else if (vld_p1 && out_ready) begin
            // Consumed with nothing new accepted behind it.
            vld_p1      <= 1'b0;
        end
    end

    assign out_valid      = vld_p1;
    assign out_rd         = rd_p1;
    assign out_imm        = imm_p1;
    assign out_ctrl       = ctrl_p1;
    assign out_mem_to_reg = memToReg_p1;
    assign out_wa         = wa_p1;
    assign out_cond       = cond_p1;
    assign out_flags      = flags_p1;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//
// Self-checking bench for decode_pipe_stage. The directed sequences follow
// the stage's intended use cases, and a randomized run follows them. All
// outputs are compared every cycle against a behavioural model of the
// register file and the D/E slot. The model honours
// DECODE_LOAD_USE_STALL_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_READ = 3;
    localparam int CTRL_W   = 12;
    localparam int RDW      = NUM_READ * DATA_W;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_READ*ADDR_W-1:0] in_ra;
    logic [ADDR_W-1:0]          in_wa;
    logic [DATA_W-1:0]          in_imm;
    logic [CTRL_W-1:0]          in_ctrl;
    logic                       in_mem_to_reg;
    logic [3:0]                 in_cond;
    logic [3:0]                 in_flags;
    logic [DATA_W-1:0]          pc_plus8;
    logic                       wb_we;
    logic [ADDR_W-1:0]          wb_wa;
    logic [DATA_W-1:0]          wb_wd;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [RDW-1:0]             out_rd;
    logic [DATA_W-1:0]          out_imm;
    logic [CTRL_W-1:0]          out_ctrl;
    logic                       out_mem_to_reg;
    logic [ADDR_W-1:0]          out_wa;
    logic [3:0]                 out_cond;
    logic [3:0]                 out_flags;

    always #5 clk = ~clk;

    decode_pipe_stage #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_READ(NUM_READ),
        .CTRL_W  (CTRL_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ra         (in_ra),
        .in_wa         (in_wa),
        .in_imm        (in_imm),
        .in_ctrl       (in_ctrl),
        .in_mem_to_reg (in_mem_to_reg),
        .in_cond       (in_cond),
        .in_flags      (in_flags),
        .pc_plus8      (pc_plus8),
        .wb_we         (wb_we),
        .wb_wa         (wb_wa),
        .wb_wd         (wb_wd),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_ctrl      (out_ctrl),
        .out_mem_to_reg(out_mem_to_reg),
        .out_wa        (out_wa),
        .out_cond      (out_cond),
        .out_flags     (out_flags)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state
    logic [DATA_W-1:0] mRf [16];
    logic              mValid = 1'b0;
    logic [RDW-1:0]    mRd    = '0;
    logic [DATA_W-1:0] mImm   = '0;
    logic [CTRL_W-1:0] mCtrl  = '0;
    logic              mMem   = 1'b0;
    logic [ADDR_W-1:0] mWa    = '0;
    logic [3:0]        mCond  = '0;
    logic [3:0]        mFlags = '0;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [ADDR_W*NUM_READ-1:0] packRa(input int a0, input int a1, input int a2);
        return {4'(a2), 4'(a1), 4'(a0)};
    endfunction

    // Register value seen by decode this cycle: R15 is the PC view,
    // a same-cycle writeback wins over the stored value.
    function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
        if (a == 4'hF) return pc_plus8;
        if (wb_we && wb_wa == a) return wb_wd;
        return mRf[a];
    endfunction

    function automatic logic refReady();
        logic rdy;
        rdy = !mValid || out_ready;
`ifdef DECODE_LOAD_USE_STALL_EN
        for (int k = 0; k < NUM_READ; k++) begin
            if (mValid && mMem && mWa != 4'hF && in_ra[k*ADDR_W +: ADDR_W] == mWa) rdy = 1'b0;
        end
`endif
        return rdy;
    endfunction

    task automatic checkOuts();
        checkVal("out_valid",      128'(out_valid),      128'(mValid));
        checkVal("out_rd",         128'(out_rd),         128'(mRd));
        checkVal("out_imm",        128'(out_imm),        128'(mImm));
        checkVal("out_ctrl",       128'(out_ctrl),       128'(mCtrl));
        checkVal("out_mem_to_reg", 128'(out_mem_to_reg), 128'(mMem));
        checkVal("out_wa",         128'(out_wa),         128'(mWa));
        checkVal("out_cond",       128'(out_cond),       128'(mCond));
        checkVal("out_flags",      128'(out_flags),      128'(mFlags));
    endtask

    // Called just after a clock edge with the inputs for the coming cycle
    // already driven; returns just after the next edge with outputs checked.
    task automatic stepCycle();
        logic           rdy;
        logic           acc;
        logic [RDW-1:0] rdNext;
        #1;
        rdy = refReady();
        if (!reset) checkVal("in_ready", 128'(in_ready), 128'(rdy));
        acc = in_valid && rdy;
        for (int k = 0; k < NUM_READ; k++) begin
            rdNext[k*DATA_W +: DATA_W] = refRead(in_ra[k*ADDR_W +: ADDR_W]);
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) mRf[i] = '0;
            mValid = 1'b0; mRd = '0; mImm = '0; mCtrl = '0;
            mMem = 1'b0; mWa = '0; mCond = '0; mFlags = '0;
        end else begin
            if (wb_we && wb_wa != 4'hF) mRf[wb_wa] = wb_wd;
            if (flush) begin
                mValid = 1'b0;
            end else if (acc) begin
                mValid = 1'b1; mRd = rdNext; mImm = in_imm; mCtrl = in_ctrl;
                mMem = in_mem_to_reg; mWa = in_wa; mCond = in_cond; mFlags = in_flags;
            end else if (mValid && out_ready) begin
                mValid = 1'b0;
            end
        end
        #1;
        checkOuts();
    endtask

    task automatic setIdle();
        reset = 1'b0; in_valid = 1'b0; in_ra = '0; in_wa = '0; in_imm = '0;
        in_ctrl = '0; in_mem_to_reg = 1'b0; in_cond = '0; in_flags = '0;
        pc_plus8 = '0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0; flush = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mRf[i] = '0;
        setIdle();

        // Reset
        reset = 1'b1;
        stepCycle();
        stepCycle();
        checkVal("reset_valid", 128'(out_valid), 128'(0));
        checkVal("reset_rd",    128'(out_rd),    128'(0));
        reset = 1'b0;

        // Reset then read: r1, r2, R15
        in_valid = 1'b1; in_ra = packRa(1, 2, 15); pc_plus8 = 32'h108;
        in_imm = 32'h11; in_cond = 4'hE; in_flags = 4'h5; in_ctrl = 12'hABC; in_wa = 4'd4;
        stepCycle();
        checkVal("read_valid", 128'(out_valid), 128'(1));
        checkVal("read_rd",    128'(out_rd),    128'({32'h108, 32'h0, 32'h0}));

        // Bypass into a same-cycle read, then the stored value
        wb_we = 1'b1; wb_wa = 4'd3; wb_wd = 32'hDEADBEEF; in_ra = packRa(3, 0, 0);
        stepCycle();
        checkVal("bypass_rd0", 128'(out_rd[31:0]), 128'(32'hDEADBEEF));
        wb_we = 1'b0; in_ra = packRa(0, 3, 0);
        stepCycle();
        checkVal("stored_rd1", 128'(out_rd[63:32]), 128'(32'hDEADBEEF));
        // A write to R15 neither lands nor bypasses
        wb_we = 1'b1; wb_wa = 4'hF; wb_wd = 32'h55; pc_plus8 = 32'h200; in_ra = packRa(15, 0, 0);
        stepCycle();
        checkVal("r15_bypass", 128'(out_rd[31:0]), 128'(32'h200));
        wb_we = 1'b0; pc_plus8 = 32'h300;
        stepCycle();
        checkVal("r15_read", 128'(out_rd[31:0]), 128'(32'h300));

        // Backpressure
        in_imm = 32'h7; in_ra = packRa(1, 2, 3);
        stepCycle();
        out_ready = 1'b0; in_imm = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal("bp_in_ready", 128'(in_ready), 128'(0));
            stepCycle();
            checkVal("bp_imm_held", 128'(out_imm), 128'(32'h7));
        end
        out_ready = 1'b1;
        stepCycle();
        checkVal("bp_release_imm", 128'(out_imm), 128'(32'h8));

        // Flush with a simultaneous new instruction
        flush = 1'b1; in_imm = 32'h9;
        stepCycle();
        checkVal("flush_valid", 128'(out_valid), 128'(0));
        checkVal("flush_imm",   128'(out_imm),   128'(32'h8));
        flush = 1'b0;

        // Throughput
        for (int i = 1; i <= 4; i++) begin
            in_imm = 32'(i);
            stepCycle();
            checkVal("tput_valid", 128'(out_valid), 128'(1));
            checkVal("tput_imm",   128'(out_imm),   128'(i));
        end

        // Load to r5 followed by a reader of r5
        in_mem_to_reg = 1'b1; in_wa = 4'd5; in_ra = packRa(0, 0, 0); in_imm = 32'h66;
        stepCycle();
        in_mem_to_reg = 1'b0; in_wa = 4'd6; in_ra = packRa(5, 1, 2); in_imm = 32'h77;
        #1;
`ifdef DECODE_LOAD_USE_STALL_EN
        checkVal("lu_in_ready", 128'(in_ready), 128'(0));
        stepCycle();
        checkVal("lu_bubble", 128'(out_valid), 128'(0));
        stepCycle();
        checkVal("lu_accept_valid", 128'(out_valid), 128'(1));
        checkVal("lu_accept_imm",   128'(out_imm),   128'(32'h77));
`else
        checkVal("lu_in_ready", 128'(in_ready), 128'(1));
        stepCycle();
        checkVal("lu_accept_valid", 128'(out_valid), 128'(1));
        checkVal("lu_accept_imm",   128'(out_imm),   128'(32'h77));
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            in_valid      = ($urandom_range(0, 9) < 8);
            out_ready     = ($urandom_range(0, 9) < 7);
            in_mem_to_reg = ($urandom_range(0, 9) < 3);
            for (int k = 0; k < NUM_READ; k++) begin
                in_ra[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            end
            in_wa    = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            in_imm   = $urandom;
            in_ctrl  = 12'($urandom);
            in_cond  = 4'($urandom);
            in_flags = 4'($urandom);
            pc_plus8 = $urandom;
            wb_we    = ($urandom_range(0, 1) == 1);
            wb_wa    = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            wb_wd    = $urandom;
            stepCycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
